cipher_byte_serializer: RTL and testbench

Ciphertext egress stage for the ECCDH3DES datapath. Captures each 64-bit block presented on the DES output strobe, buffers up to DEPTH blocks, and emits them as a byte stream, most-significant byte first, over a valid/ready handshake. It is the reader for the DES block writer: the consumer of `encrypted_data`/`data_valid_out` that feeds a byte-wide host or file sink.

---
 rtl/cipher_byte_serializer.sv | 136 +++++++++++++
 tb/tb_cipher_byte_serializer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_byte_serializer.sv
// Ciphertext egress stage: buffers 64-bit cipher blocks in a small FIFO and
// streams them out MSB-first as bytes over a valid/ready handshake.
module cipher_byte_serializer #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [63:0]   block_in,
    input  logic          block_valid,
    output logic [7:0]    byte_out,
    output logic          byte_valid,
    input  logic          byte_ready,
    output logic          block_sent,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    input  logic          ovf_clr
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [63:0]   shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          block_sent_q, block_sent_d;
    logic [63:0]   mem_q [DEPTH];

    logic push;
    logic pop;
    logic drop;
    logic full;
    logic nonempty;

    assign full       = (count_q == CW'(DEPTH));
    assign nonempty   = (count_q != '0);
    assign byte_out   = shift_q[63:56];
    assign byte_valid = (state_q == SEND);
    assign block_sent = block_sent_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

    // Next-state: serializer FSM, FIFO pointer/count bookkeeping and overflow flag.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        block_sent_d = 1'b0;
        pop          = 1'b0;

        case (state_q)
            IDLE: begin
                // A block pushed this cycle is not visible yet: no bypass.
                if (nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    if (idx_q != 3'd7) begin
                        shift_d = {shift_q[55:0], 8'h00};
                        idx_d   = idx_q + 3'd1;
                    end else begin
                        block_sent_d = 1'b1;
                        if (nonempty) begin
                            // Chain straight into the next block: no bubble.
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            idx_d   = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push = block_valid && (!full || pop);
        drop = block_valid && full && !pop;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Drop wins over clear so a coincident drop is never lost.
        if (drop)         overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
    end

    // State registers; reset discards any partial block and all queued blocks.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            block_sent_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            block_sent_q <= block_sent_d;
        end
    end

    // FIFO storage; contents are meaningless after reset since pointers/count clear.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= block_in;
    end

endmodule

// File: tb/tb_cipher_byte_serializer.sv
// Directed bench for cipher_byte_serializer: a vector table for a single
// block plus hand-written sequences for stalls, chaining, overflow and reset.
module tb_cipher_byte_serializer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [63:0] block_in;
    logic        block_valid;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        block_sent;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        ovf_clr;

    cipher_byte_serializer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .block_in   (block_in),
        .block_valid(block_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .block_sent (block_sent),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        bv;
        logic [63:0] blk;
        logic        rdy;
        logic        clr;
        logic        e_vld;
        logic [7:0]  e_byte;
        logic        e_sent;
        logic [2:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t        tbl [11];
    logic [63:0] sblk [$];
    logic [63:0] eblk [$];
    logic [7:0]  got  [$];
    int          sent_cnt;
    int          max_cnt;
    int          first_acc;
    int          last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        n_rst       = 1'b0;
        block_valid = 1'b0;
        block_in    = '0;
        byte_ready  = 1'b0;
        ovf_clr     = 1'b0;
        repeat (2) tick;
        n_rst = 1'b1;
        tick;
    endtask

    // Cycle-by-cycle driver/collector: strobes sblk[0..nstrobe-1], drives ready
    // (mode 0: always 1, mode 1: 1,0,0,1 repeating) and records accepted bytes.
    task automatic run(input int nstrobe, input int mode, input int nbytes, input int maxcyc);
        bit         stalled = 1'b0;
        logic [7:0] pb = '0;
        int         c = 0;
        got.delete();
        sent_cnt  = 0;
        max_cnt   = 0;
        first_acc = -1;
        last_acc  = -1;
        while (got.size() < nbytes && c < maxcyc) begin
            block_valid = (c < nstrobe);
            block_in    = (c < nstrobe) ? sblk[c] : 64'h0;
            byte_ready  = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (stalled) begin
                chk("stall_valid", byte_valid, 1);
                chk("stall_byte", byte_out, pb);
            end
            if (byte_valid && byte_ready) begin
                got.push_back(byte_out);
                if (first_acc < 0) first_acc = c;
                last_acc = c;
            end
            stalled = byte_valid && !byte_ready;
            pb      = byte_out;
            tick;
            c++;
            if (block_sent) sent_cnt++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        block_valid = 1'b0;
        byte_ready  = 1'b0;
        chk("byte_count", got.size(), nbytes);
    endtask

    task automatic cmp_bytes(input string name);
        logic [7:0] exp [$];
        foreach (eblk[b])
            for (int k = 0; k < 8; k++) exp.push_back(eblk[b][63 - 8*k -: 8]);
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), got[i], exp[i]);
    endtask

    initial begin
        logic [63:0] ob [6];
        logic [63:0] sb;
        sb = 64'h6465616462656566;
        for (int i = 0; i < 6; i++) ob[i] = 64'h0102030405060708 + 64'(i) * 64'h1010101010101010;

        // ---------------- reset state ----------------
        do_reset;
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_out", byte_out, 0);
        chk("rst_block_sent", block_sent, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);

        // ---------------- single block, table driven ----------------
        tbl[0]  = '{1'b1, sb,    1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0};
        tbl[1]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 8'h64, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 8'h65, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 8'h61, 1'b0, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 8'h64, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 8'h62, 1'b0, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 8'h65, 1'b0, 3'd0, 1'b0};
        tbl[7]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 8'h65, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 3'd0, 1'b0};
        tbl[9]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};
        tbl[10] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            block_valid = tbl[i].bv;
            block_in    = tbl[i].blk;
            byte_ready  = tbl[i].rdy;
            ovf_clr     = tbl[i].clr;
            tick;
            chk($sformatf("vec%0d_valid", i), byte_valid, tbl[i].e_vld);
            if (tbl[i].e_vld) chk($sformatf("vec%0d_byte", i), byte_out, tbl[i].e_byte);
            chk($sformatf("vec%0d_sent", i), block_sent, tbl[i].e_sent);
            chk($sformatf("vec%0d_count", i), fifo_count, tbl[i].e_cnt);
            chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].e_ovf);
        end
        block_valid = 1'b0;
        byte_ready  = 1'b0;
        ovf_clr     = 1'b0;

        // ---------------- backpressure ----------------
        do_reset;
        sblk = '{sb};
        eblk = '{sb};
        run(1, 1, 8, 200);
        cmp_bytes("bp");
        chk("bp_sent_cnt", sent_cnt, 1);
        tick;
        chk("bp_idle_valid", byte_valid, 0);
        chk("bp_idle_count", fifo_count, 0);

        // ---------------- back-to-back blocks ----------------
        do_reset;
        sblk = '{64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0};
        eblk = sblk;
        run(3, 0, 24, 200);
        cmp_bytes("b2b");
        chk("b2b_contiguous", last_acc - first_acc, 23);
        chk("b2b_first_latency", first_acc, 2);
        chk("b2b_peak_count", max_cnt, 2);
        chk("b2b_sent_cnt", sent_cnt, 3);
        chk("b2b_end_valid", byte_valid, 0);
        chk("b2b_end_count", fifo_count, 0);

        // ---------------- overflow ----------------
        do_reset;
        for (int i = 0; i < 6; i++) begin
            block_valid = 1'b1;
            block_in    = ob[i];
            tick;
        end
        block_valid = 1'b0;
        chk("ovf_count_full", fifo_count, 4);
        chk("ovf_set", overflow, 1);
        chk("ovf_head_valid", byte_valid, 1);
        chk("ovf_head_byte", byte_out, ob[0][63:56]);
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        ovf_clr     = 1'b1;
        block_valid = 1'b1;
        block_in    = 64'hDEADBEEFDEADBEEF;
        tick;
        ovf_clr     = 1'b0;
        block_valid = 1'b0;
        chk("ovf_clr_vs_drop", overflow, 1);
        chk("ovf_count_unchanged", fifo_count, 4);
        tick;
        chk("ovf_sticky", overflow, 1);
        eblk = '{ob[0], ob[1], ob[2], ob[3], ob[4]};
        run(0, 0, 40, 200);
        cmp_bytes("ovf_drain");
        chk("ovf_drain_sent", sent_cnt, 5);
        byte_ready = 1'b1;
        repeat (3) begin
            tick;
            chk("ovf_no_extra_byte", byte_valid, 0);
        end
        chk("ovf_drain_count", fifo_count, 0);
        byte_ready = 1'b0;

        // ---------------- full FIFO with simultaneous pop ----------------
        do_reset;
        for (int i = 0; i < 5; i++) begin
            block_valid = 1'b1;
            block_in    = ob[i];
            tick;
        end
        block_valid = 1'b0;
        chk("fp_count_full", fifo_count, 4);
        byte_ready = 1'b1;
        repeat (7) tick;
        chk("fp_byte7", byte_out, ob[0][7:0]);
        block_valid = 1'b1;
        block_in    = ob[5];
        tick;
        block_valid = 1'b0;
        byte_ready  = 1'b0;
        chk("fp_sent", block_sent, 1);
        chk("fp_count_stays", fifo_count, 4);
        chk("fp_no_ovf", overflow, 0);
        chk("fp_next_valid", byte_valid, 1);
        chk("fp_next_byte", byte_out, ob[1][63:56]);
        eblk = '{ob[1], ob[2], ob[3], ob[4], ob[5]};
        run(0, 0, 40, 200);
        cmp_bytes("fp_drain");
        chk("fp_drain_sent", sent_cnt, 5);

        // ---------------- asynchronous reset mid-block ----------------
        do_reset;
        block_valid = 1'b1;
        block_in    = sb;
        tick;
        block_in    = ob[2];
        tick;
        block_valid = 1'b0;
        byte_ready  = 1'b1;
        repeat (3) tick;
        chk("mid_byte3", byte_out, sb[39:32]);
        chk("mid_count", fifo_count, 1);
        n_rst = 1'b0;
        #1;
        chk("arst_valid", byte_valid, 0);
        chk("arst_byte", byte_out, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_sent", block_sent, 0);
        chk("arst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (12) begin
            tick;
            chk("post_rst_quiet", byte_valid, 0);
        end
        chk("post_rst_count", fifo_count, 0);
        byte_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
